// File: rtl/store_buffer6.sv
// store_buffer6: six-entry FIFO of committed stores feeding the dcache write port.
// Also compares each load against live entries and registers match/partial/forward data.
module store_buffer6 (
    input  logic        cpu_clock_i,
    input  logic        cpu_reset_i,
    input  logic        enq_valid_i,
    output logic        enq_ready_o,
    input  logic [29:0] enq_addr_i,
    input  logic [31:0] enq_data_i,
    input  logic [3:0]  enq_mask_i,
    output logic        drn_valid_o,
    input  logic        drn_ready_i,
    output logic [29:0] drn_addr_o,
    output logic [31:0] drn_data_o,
    output logic [3:0]  drn_mask_o,
    input  logic        lk_valid_i,
    input  logic [29:0] lk_addr_i,
    input  logic [3:0]  lk_mask_i,
    output logic        lk_valid_o,
    output logic [5:0]  lk_match_o,
    output logic        lk_partial_o,
    output logic [31:0] lk_data_o
);

    logic [29:0] addr_q [6];
    logic [31:0] data_q [6];
    logic [3:0]  mask_q [6];
    logic [5:0]  valid_q;
    logic [2:0]  head_q;
    logic [2:0]  tail_q;
    logic [2:0]  count_q;

    logic        enq_fire;
    logic        drn_fire;
    logic [5:0]  addr_eq;
    logic [5:0]  full;
    logic [5:0]  part;
    logic [31:0] fwd_data;

    function automatic logic [2:0] ptr_inc(input logic [2:0] p);
        return (p == 3'd5) ? 3'd0 : p + 3'd1;
    endfunction

    assign enq_ready_o = (count_q < 3'd6);
    assign drn_valid_o = (count_q != 3'd0);
    assign enq_fire    = enq_valid_i & enq_ready_o;
    assign drn_fire    = drn_valid_o & drn_ready_i;

    assign drn_addr_o  = addr_q[head_q];
    assign drn_data_o  = data_q[head_q];
    assign drn_mask_o  = mask_q[head_q];

    // Slot payload is never reset; valid_q alone decides liveness.
    always_ff @(posedge cpu_clock_i) begin
        if (enq_fire) begin
            addr_q[tail_q] <= enq_addr_i;
            data_q[tail_q] <= enq_data_i;
            mask_q[tail_q] <= enq_mask_i;
        end
    end

    always_ff @(posedge cpu_clock_i) begin
        if (cpu_reset_i) begin
            head_q  <= 3'd0;
            tail_q  <= 3'd0;
            count_q <= 3'd0;
            valid_q <= 6'd0;
        end else begin
            if (enq_fire) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= ptr_inc(tail_q);
            end
            if (drn_fire) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= ptr_inc(head_q);
            end
            count_q <= count_q + {2'b00, enq_fire} - {2'b00, drn_fire};
        end
    end

    always_comb begin
        addr_eq  = 6'd0;
        full     = 6'd0;
        part     = 6'd0;
        fwd_data = 32'd0;
        for (int i = 0; i < 6; i++) begin
            addr_eq[i] = valid_q[i] & (addr_q[i] == lk_addr_i);
            full[i]    = addr_eq[i]
                       & ((mask_q[i] & lk_mask_i) == lk_mask_i)
                       & (lk_mask_i != 4'd0);
            part[i]    = addr_eq[i] & (|(mask_q[i] & lk_mask_i)) & ~full[i];
            if (full[i]) begin
                fwd_data = fwd_data | data_q[i];
            end
        end
    end

    always_ff @(posedge cpu_clock_i) begin
        if (cpu_reset_i) begin
            lk_valid_o   <= 1'b0;
            lk_match_o   <= 6'd0;
            lk_partial_o <= 1'b0;
            lk_data_o    <= 32'd0;
        end else begin
            lk_valid_o   <= lk_valid_i;
            lk_match_o   <= full & {6{lk_valid_i}};
            lk_partial_o <= lk_valid_i & (|part);
            lk_data_o    <= fwd_data;
        end
    end

endmodule

// File: tb/tb_store_buffer6.sv
// tb_store_buffer6: scoreboard against a FIFO reference model plus
// table-driven lookup vectors and directed drain/wrap/reset sequences.
module tb_store_buffer6;

    logic        clk = 1'b0;
    logic        cpu_reset_i;
    logic        enq_valid_i;
    logic        enq_ready_o;
    logic [29:0] enq_addr_i;
    logic [31:0] enq_data_i;
    logic [3:0]  enq_mask_i;
    logic        drn_valid_o;
    logic        drn_ready_i;
    logic [29:0] drn_addr_o;
    logic [31:0] drn_data_o;
    logic [3:0]  drn_mask_o;
    logic        lk_valid_i;
    logic [29:0] lk_addr_i;
    logic [3:0]  lk_mask_i;
    logic        lk_valid_o;
    logic [5:0]  lk_match_o;
    logic        lk_partial_o;
    logic [31:0] lk_data_o;

    always #5 clk = ~clk;

    store_buffer6 dut (
        .cpu_clock_i (clk),
        .cpu_reset_i (cpu_reset_i),
        .enq_valid_i (enq_valid_i),
        .enq_ready_o (enq_ready_o),
        .enq_addr_i  (enq_addr_i),
        .enq_data_i  (enq_data_i),
        .enq_mask_i  (enq_mask_i),
        .drn_valid_o (drn_valid_o),
        .drn_ready_i (drn_ready_i),
        .drn_addr_o  (drn_addr_o),
        .drn_data_o  (drn_data_o),
        .drn_mask_o  (drn_mask_o),
        .lk_valid_i  (lk_valid_i),
        .lk_addr_i   (lk_addr_i),
        .lk_mask_i   (lk_mask_i),
        .lk_valid_o  (lk_valid_o),
        .lk_match_o  (lk_match_o),
        .lk_partial_o(lk_partial_o),
        .lk_data_o   (lk_data_o)
    );

    typedef struct packed {
        logic        v;
        logic [5:0]  m;
        logic        p;
        logic [31:0] d;
    } lk_exp_t;

    typedef struct packed {
        logic [29:0] a;
        logic [3:0]  mk;
        logic        v;
        logic [5:0]  m;
        logic        p;
        logic [31:0] d;
    } vec_t;

    lk_exp_t sbq[$];

    logic [29:0] ma [6];
    logic [31:0] md [6];
    logic [3:0]  mm [6];
    logic [5:0]  mv;
    int          mhead;
    int          mtail;
    int          mcount;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: predict the registered lookup, advance the model, compare.
    task automatic step();
        lk_exp_t     e;
        logic        en;
        logic        dn;
        logic        rst;
        logic        any_p;
        logic [29:0] ea;
        logic [31:0] ed;
        logic [3:0]  em;
        e     = '0;
        any_p = 1'b0;
        rst   = cpu_reset_i;
        if (!rst) begin
            for (int i = 0; i < 6; i++) begin
                logic eq;
                logic fl;
                eq = mv[i] && (ma[i] == lk_addr_i);
                fl = eq && ((mm[i] & lk_mask_i) == lk_mask_i)
                     && (lk_mask_i != 4'd0);
                if (fl) begin
                    e.d = e.d | md[i];
                    e.m[i] = lk_valid_i;
                end
                if (eq && (|(mm[i] & lk_mask_i)) && !fl) any_p = 1'b1;
            end
            e.v = lk_valid_i;
            e.p = lk_valid_i & any_p;
        end
        sbq.push_back(e);
        en = enq_valid_i && (mcount < 6);
        dn = drn_ready_i && (mcount != 0);
        ea = enq_addr_i;
        ed = enq_data_i;
        em = enq_mask_i;
        @(posedge clk);
        if (rst) begin
            mhead = 0; mtail = 0; mcount = 0; mv = '0;
        end else begin
            if (en) begin
                ma[mtail] = ea; md[mtail] = ed; mm[mtail] = em;
                mv[mtail] = 1'b1;
                mtail = (mtail == 5) ? 0 : mtail + 1;
            end
            if (dn) begin
                mv[mhead] = 1'b0;
                mhead = (mhead == 5) ? 0 : mhead + 1;
            end
            mcount = mcount + (en ? 1 : 0) - (dn ? 1 : 0);
        end
        #1;
        e = sbq.pop_front();
        chk("sb_lk_valid", 64'(lk_valid_o), 64'(e.v));
        chk("sb_lk_match", 64'(lk_match_o), 64'(e.m));
        chk("sb_lk_partial", 64'(lk_partial_o), 64'(e.p));
        chk("sb_lk_data", 64'(lk_data_o), 64'(e.d));
        chk("sb_enq_ready", 64'(enq_ready_o), 64'(mcount < 6));
        chk("sb_drn_valid", 64'(drn_valid_o), 64'(mcount != 0));
        if (mcount != 0) begin
            chk("sb_drn_addr", 64'(drn_addr_o), 64'(ma[mhead]));
            chk("sb_drn_data", 64'(drn_data_o), 64'(md[mhead]));
            chk("sb_drn_mask", 64'(drn_mask_o), 64'(mm[mhead]));
        end
    endtask

    task automatic enq(input logic [29:0] a, input logic [31:0] d,
                       input logic [3:0] m);
        enq_valid_i = 1'b1;
        enq_addr_i  = a;
        enq_data_i  = d;
        enq_mask_i  = m;
        step();
        enq_valid_i = 1'b0;
    endtask

    task automatic lk(input logic [29:0] a, input logic [3:0] m);
        lk_valid_i = 1'b1;
        lk_addr_i  = a;
        lk_mask_i  = m;
        step();
        lk_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        cpu_reset_i = 1'b1;
        step();
        cpu_reset_i = 1'b0;
    endtask

    vec_t        vecs [10];
    logic [29:0] tail_order [5];

    initial begin
        cpu_reset_i = 1'b1;
        enq_valid_i = 1'b0;
        enq_addr_i  = '0;
        enq_data_i  = '0;
        enq_mask_i  = '0;
        drn_ready_i = 1'b0;
        lk_valid_i  = 1'b0;
        lk_addr_i   = '0;
        lk_mask_i   = '0;
        mhead = 0; mtail = 0; mcount = 0; mv = '0;
        for (int i = 0; i < 6; i++) begin
            ma[i] = '0; md[i] = '0; mm[i] = '0;
        end

        vecs[0] = '{30'h40, 4'b0011, 1'b1, 6'b000100, 1'b0, 32'hDEADBEEF};
        vecs[1] = '{30'h50, 4'b0011, 1'b1, 6'b000000, 1'b1, 32'h0};
        vecs[2] = '{30'h80, 4'b1111, 1'b1, 6'b000011, 1'b0, 32'h33333333};
        vecs[3] = '{30'h50, 4'b0001, 1'b1, 6'b001000, 1'b0, 32'h000000AA};
        vecs[4] = '{30'h60, 4'b0001, 1'b1, 6'b000000, 1'b0, 32'h0};
        vecs[5] = '{30'h70, 4'b0000, 1'b1, 6'b000000, 1'b0, 32'h0};
        vecs[6] = '{30'h70, 4'b0110, 1'b1, 6'b000000, 1'b1, 32'h0};
        vecs[7] = '{30'h70, 4'b1000, 1'b1, 6'b100000, 1'b0, 32'hCAFE0000};
        vecs[8] = '{30'h99, 4'b1111, 1'b1, 6'b000000, 1'b0, 32'h0};
        vecs[9] = '{30'h40, 4'b0011, 1'b0, 6'b000000, 1'b0, 32'hDEADBEEF};
        tail_order = '{30'h34, 30'h35, 30'h39, 30'h3A, 30'h3B};

        step();
        cpu_reset_i = 1'b0;
        chk("rst_enq_ready", 64'(enq_ready_o), 64'd1);
        chk("rst_drn_valid", 64'(drn_valid_o), 64'd0);
        chk("rst_lk_match", 64'(lk_match_o), 64'd0);
        chk("rst_lk_data", 64'(lk_data_o), 64'd0);

        // Fill, blocked 7th enqueue, then drain in order.
        for (int k = 0; k < 6; k++)
            enq(30'(32'h10 + k), 32'h1000 + k, 4'hF);
        chk("full_ready", 64'(enq_ready_o), 64'd0);
        enq(30'h77, 32'h77, 4'hF);
        chk("full_head", 64'(drn_addr_o), 64'h10);
        drn_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk("drain_order", 64'(drn_addr_o), 64'(32'h10 + k));
            step();
        end
        drn_ready_i = 1'b0;
        chk("drained_empty", 64'(drn_valid_o), 64'd0);

        // Move head/tail to 3, fill, then overlap enqueue and drain.
        for (int k = 0; k < 3; k++)
            enq(30'(32'h20 + k), 32'h2000 + k, 4'hF);
        drn_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) step();
        drn_ready_i = 1'b0;
        for (int k = 0; k < 6; k++)
            enq(30'(32'h30 + k), 32'h3000 + k, 4'(k));
        chk("wrap_full", 64'(enq_ready_o), 64'd0);
        enq_valid_i = 1'b1;
        drn_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            enq_addr_i = 30'(32'h38 + k);
            enq_data_i = 32'h3800 + k;
            enq_mask_i = 4'hF;
            chk("wrap_drain", 64'(drn_addr_o), 64'(32'h30 + k));
            step();
        end
        enq_valid_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("wrap_tail", 64'(drn_addr_o), 64'(tail_order[k]));
            step();
        end
        drn_ready_i = 1'b0;
        chk("wrap_empty", 64'(drn_valid_o), 64'd0);

        // Reset mid-fill wins over enqueue and in-flight lookup.
        enq(30'hA0, 32'hA0, 4'hF);
        enq(30'hA1, 32'hA1, 4'hF);
        enq_valid_i = 1'b1;
        enq_addr_i  = 30'hA2;
        lk_valid_i  = 1'b1;
        lk_addr_i   = 30'hA0;
        lk_mask_i   = 4'hF;
        do_reset();
        enq_valid_i = 1'b0;
        lk_valid_i  = 1'b0;
        chk("rst_mid_lkv", 64'(lk_valid_o), 64'd0);
        chk("rst_mid_match", 64'(lk_match_o), 64'd0);
        chk("rst_mid_ready", 64'(enq_ready_o), 64'd1);
        lk(30'hA0, 4'hF);
        chk("rst_old_match", 64'(lk_match_o), 64'd0);

        // Same-cycle enqueue is not compared; visible next cycle.
        lk_valid_i = 1'b1;
        lk_addr_i  = 30'h99;
        lk_mask_i  = 4'hF;
        enq(30'h99, 32'h99999999, 4'hF);
        lk_valid_i = 1'b0;
        chk("same_cyc_match", 64'(lk_match_o), 64'd0);
        lk(30'h99, 4'hF);
        chk("next_cyc_match", 64'(lk_match_o), 64'b000001);
        chk("next_cyc_data", 64'(lk_data_o), 64'h99999999);

        // Known slot image for the lookup vector table.
        do_reset();
        enq(30'h80, 32'h11111111, 4'hF);
        enq(30'h80, 32'h22222222, 4'hF);
        enq(30'h40, 32'hDEADBEEF, 4'hF);
        enq(30'h50, 32'h000000AA, 4'b0001);
        enq(30'h60, 32'h12345678, 4'b0000);
        enq(30'h70, 32'hCAFE0000, 4'b1100);
        for (int k = 0; k < 10; k++) begin
            lk_valid_i = vecs[k].v;
            lk_addr_i  = vecs[k].a;
            lk_mask_i  = vecs[k].mk;
            step();
            chk($sformatf("vec%0d_match", k), 64'(lk_match_o), 64'(vecs[k].m));
            chk($sformatf("vec%0d_part", k), 64'(lk_partial_o), 64'(vecs[k].p));
            chk($sformatf("vec%0d_data", k), 64'(lk_data_o), 64'(vecs[k].d));
        end
        lk_valid_i = 1'b0;

        // Entry drained at this edge is still compared this cycle.
        drn_ready_i = 1'b1;
        lk(30'h80, 4'hF);
        drn_ready_i = 1'b0;
        chk("drain_same_match", 64'(lk_match_o), 64'b000011);
        lk(30'h80, 4'hF);
        chk("drain_after_match", 64'(lk_match_o), 64'b000010);
        chk("drain_after_data", 64'(lk_data_o), 64'h22222222);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
